cache_req_sequencer: RTL and testbench

Upstream request sequencer for the two-entry line cache. Buffers read/write requests from the requester in a small FIFO, issues them one at a time on the cache's `read`/`write`/`in_addr`/`in_val` pins, and follows the cache's multi-cycle write-miss protocol. It samples `hit`/`out_val` at the correct cycle and returns one response per request over a valid/ready channel.

---
 rtl/cache_req_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_cache_req_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_req_sequencer.sv
// Request sequencer in front of the two-entry line cache. Optional build macro:
// CACHE_SEQ_STATS_EN adds saturating stat_hits / stat_misses response counters.
//
// Purpose: queue read/write requests, issue one at a time to the cache, follow its write-miss protocol.
// Latency: read response 4 cycles after push; write response 2 cycles after issue on hit, 3 on miss.
// Backpressure: req_ready drops when the request FIFO is full; resp_* hold stable until resp_ready.
module cache_req_sequencer #(
    parameter int ADDR_WIDTH = 8,
    parameter int LINE_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int WR_TIMEOUT = 15
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LINE_WIDTH-1:0] req_data,
    output logic                  c_read,
    output logic                  c_write,
    output logic [ADDR_WIDTH-1:0] c_addr,
    output logic [LINE_WIDTH-1:0] c_val,
    input  logic                  c_hit,
    input  logic [LINE_WIDTH-1:0] c_out_val,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  resp_hit,
    output logic [LINE_WIDTH-1:0] resp_data,
    output logic                  resp_err
`ifdef CACHE_SEQ_STATS_EN
    ,
    output logic [15:0]           stat_hits,
    output logic [15:0]           stat_misses
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMO_W = $clog2(WR_TIMEOUT + 1);

    typedef struct packed {
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [LINE_WIDTH-1:0] data;
    } req_t;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_SAMPLE,
        WR_ISSUE,
        WR_WAIT,
        RESP
    } state_t;

    state_t           state;
    state_t           state_nxt;

    req_t             fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;
    logic             head_vld;
    req_t             push_dat;
    req_t             head_dat;

    req_t             op;
    logic [TMO_W-1:0] wait_cnt;
    logic             first_hit;
    logic             wr_tmo;

    // Ready comes from the registered count only, so a same-cycle pop never opens a slot.
    assign req_ready = (count != CNT_W'(DEPTH));
    assign head_vld  = (count != '0);
    assign push      = req_valid && req_ready;
    assign push_dat  = '{write: req_write, addr: req_addr, data: req_data};
    assign head_dat  = fifo_mem[rd_ptr];

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // FIFO storage; contents are don't-care until the count says otherwise.
    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr] <= push_dat;
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state and cache-side pins; c_read and c_write live in disjoint states.
    always_comb begin
        state_nxt  = state;
        pop        = 1'b0;
        wr_tmo     = 1'b0;
        c_read     = 1'b0;
        c_write    = 1'b0;
        c_addr     = '0;
        c_val      = '0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                if (head_vld) begin
                    pop       = 1'b1;
                    state_nxt = head_dat.write ? WR_ISSUE : RD_ISSUE;
                end
            end
            RD_ISSUE: begin
                c_read    = 1'b1;
                c_addr    = op.addr;
                state_nxt = RD_SAMPLE;
            end
            RD_SAMPLE: begin
                state_nxt = RESP;
            end
            WR_ISSUE: begin
                c_write   = 1'b1;
                c_addr    = op.addr;
                c_val     = op.data;
                state_nxt = WR_WAIT;
            end
            WR_WAIT: begin
                c_write = 1'b1;
                c_addr  = op.addr;
                c_val   = op.data;
                if (c_hit) begin
                    state_nxt = RESP;
                end else if (wait_cnt == TMO_W'(WR_TIMEOUT - 1)) begin
                    wr_tmo    = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Op capture, write-wait bookkeeping and response registers (held untouched in RESP).
    always_ff @(posedge clock) begin
        if (reset) begin
            op        <= '0;
            wait_cnt  <= '0;
            first_hit <= 1'b0;
            resp_hit  <= 1'b0;
            resp_data <= '0;
            resp_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) op <= head_dat;
                end
                RD_SAMPLE: begin
                    resp_hit  <= c_hit;
                    resp_data <= c_hit ? c_out_val : '0;
                    resp_err  <= 1'b0;
                end
                WR_ISSUE: begin
                    wait_cnt <= '0;
                end
                WR_WAIT: begin
                    // wait_cnt is still zero only on the first compare cycle.
                    if (wait_cnt == '0) first_hit <= c_hit;
                    if (c_hit) begin
                        resp_hit  <= (wait_cnt == '0) ? c_hit : first_hit;
                        resp_data <= '0;
                        resp_err  <= 1'b0;
                    end else if (wr_tmo) begin
                        resp_hit  <= 1'b0;
                        resp_data <= '0;
                        resp_err  <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + TMO_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CACHE_SEQ_STATS_EN
    // Hit/miss tally per accepted response; a timeout reports hit=0 and so counts as a miss.
    always_ff @(posedge clock) begin
        if (reset) begin
            stat_hits   <= '0;
            stat_misses <= '0;
        end else if (resp_valid && resp_ready) begin
            if (resp_hit) begin
                if (stat_hits != 16'hFFFF) stat_hits <= stat_hits + 16'd1;
            end else begin
                if (stat_misses != 16'hFFFF) stat_misses <= stat_misses + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_req_sequencer.sv
// Purpose: directed bench for cache_req_sequencer against a behavioural two-entry line cache.
// Latency: checks read, write-hit, write-miss and write-timeout cycle counts from push.
// Backpressure: fills the FIFO behind a stalled response, then drains in order.
module tb_cache_req_sequencer;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [7:0]  req_addr;
    logic [31:0] req_data;
    logic        c_read;
    logic        c_write;
    logic [7:0]  c_addr;
    logic [31:0] c_val;
    logic        c_hit;
    logic [31:0] c_out_val;
    logic        resp_valid;
    logic        resp_ready;
    logic        resp_hit;
    logic [31:0] resp_data;
    logic        resp_err;
`ifdef CACHE_SEQ_STATS_EN
    logic [15:0] stat_hits;
    logic [15:0] stat_misses;
`endif

    int checks = 0;
    int passes = 0;
    int both_hi = 0;
    bit never_hit = 0;

    // Backpressure batch: read 0x42, read 0x33, write 0x20, read 0x20.
    logic        bp_wr    [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0]  bp_addr  [4] = '{8'h42, 8'h33, 8'h20, 8'h20};
    logic [31:0] bp_data  [4] = '{32'h0, 32'h0, 32'h11112222, 32'h0};
    logic        bp_hit   [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] bp_rdata [4] = '{32'hDEADBEEF, 32'h0, 32'h0, 32'h11112222};

    cache_req_sequencer #(
        .ADDR_WIDTH(8),
        .LINE_WIDTH(32),
        .DEPTH(4),
        .WR_TIMEOUT(15)
    ) dut (
        .clock(clock),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr(req_addr),
        .req_data(req_data),
        .c_read(c_read),
        .c_write(c_write),
        .c_addr(c_addr),
        .c_val(c_val),
        .c_hit(c_hit),
        .c_out_val(c_out_val),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_hit(resp_hit),
        .resp_data(resp_data),
`ifdef CACHE_SEQ_STATS_EN
        .stat_hits(stat_hits),
        .stat_misses(stat_misses),
`endif
        .resp_err(resp_err)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Cache model: registered hit/out_val; a write miss installs the line on the second write cycle.
    initial begin
        logic        rd;
        logic        wr;
        logic [7:0]  a;
        logic [31:0] v;
        logic [7:0]  m_addr [2];
        logic [31:0] m_data [2];
        int          victim;
        int          idx;
        bit          fill_pending;
        m_addr[0] = 8'h10; m_data[0] = 32'hCAFE0010;
        m_addr[1] = 8'h20; m_data[1] = 32'h12345678;
        victim = 0;
        fill_pending = 0;
        c_hit = 1'b0;
        c_out_val = '0;
        forever begin
            @(negedge clock);
            rd = c_read; wr = c_write; a = c_addr; v = c_val;
            @(posedge clock);
            #1;
            idx = -1;
            for (int i = 0; i < 2; i++) if (m_addr[i] === a) idx = i;
            if (rd === 1'b1) begin
                fill_pending = 0;
                if (idx >= 0) begin c_hit = 1'b1; c_out_val = m_data[idx]; end
                else          begin c_hit = 1'b0; c_out_val = 32'hBAD0BAD0; end
            end else if (wr === 1'b1) begin
                if (never_hit) begin
                    c_hit = 1'b0;
                end else if (idx >= 0) begin
                    m_data[idx] = v; c_hit = 1'b1; fill_pending = 0;
                end else if (fill_pending) begin
                    m_addr[victim] = a; m_data[victim] = v; victim = 1 - victim;
                    c_hit = 1'b1; fill_pending = 0;
                end else begin
                    fill_pending = 1; c_hit = 1'b0;
                end
            end else begin
                c_hit = 1'b0; c_out_val = '0; fill_pending = 0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic push(input logic wr, input logic [7:0] a, input logic [31:0] d);
        @(negedge clock);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_data = d;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
    endtask

    // Observe n cycles (k=1 is the cycle after the push edge) with resp_ready low.
    task automatic watch(input int n, output int rd_n, output int wr_n, output int rd_k,
                         output int wr_k, output int resp_k, output logic [7:0] addr,
                         output logic [31:0] val);
        rd_n = 0; wr_n = 0; rd_k = 0; wr_k = 0; resp_k = 0; addr = '0; val = '0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clock);
            if (c_read && c_write) both_hi++;
            if (c_read) begin
                rd_n++;
                if (rd_k == 0) begin rd_k = k; addr = c_addr; end
            end
            if (c_write) begin
                wr_n++;
                if (wr_k == 0) begin wr_k = k; addr = c_addr; val = c_val; end
            end
            if (resp_valid && resp_k == 0) resp_k = k;
        end
    endtask

    task automatic accept(input string tag, input logic e_hit, input logic [31:0] e_data,
                          input logic e_err);
        chk({tag, "_valid"}, resp_valid, 1);
        chk({tag, "_hit"}, resp_hit, e_hit);
        chk({tag, "_data"}, resp_data, e_data);
        chk({tag, "_err"}, resp_err, e_err);
        resp_ready = 1'b1;
        @(posedge clock);
        #1;
        resp_ready = 1'b0;
    endtask

    task automatic wait_resp(input int max);
        for (int i = 0; i < max && resp_valid !== 1'b1; i++) @(negedge clock);
    endtask

    task automatic do_op(input string tag, input logic wr, input logic [7:0] a,
                         input logic [31:0] d, input int n, input int e_rd, input int e_wr,
                         input int e_resp, input logic e_hit, input logic [31:0] e_data,
                         input logic e_err);
        int rd_n, wr_n, rd_k, wr_k, resp_k;
        logic [7:0] o_addr;
        logic [31:0] o_val;
        push(wr, a, d);
        watch(n, rd_n, wr_n, rd_k, wr_k, resp_k, o_addr, o_val);
        chk({tag, "_rd_cycles"}, rd_n, e_rd);
        chk({tag, "_wr_cycles"}, wr_n, e_wr);
        chk({tag, "_issue_at"}, wr ? wr_k : rd_k, 2);
        chk({tag, "_resp_at"}, resp_k, e_resp);
        chk({tag, "_addr"}, o_addr, a);
        if (wr) chk({tag, "_val"}, o_val, d);
        accept(tag, e_hit, e_data, e_err);
    endtask

    // Directed sequence.
    initial begin
        int rd_n, wr_n, rd_k, wr_k, resp_k;
        logic [7:0] o_addr;
        logic [31:0] o_val;
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_data = '0;
        resp_ready = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_c_read", c_read, 0);
        chk("rst_c_write", c_write, 0);
        chk("rst_c_addr", c_addr, 0);
        chk("rst_c_val", c_val, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_hit", resp_hit, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_resp_data", resp_data, 0);
        reset = 1'b0;

        do_op("rd_hit",    1'b0, 8'h10, 32'h0,        8, 1, 0, 4, 1'b1, 32'hCAFE0010, 1'b0);
        do_op("rd_miss",   1'b0, 8'h33, 32'h0,        8, 1, 0, 4, 1'b0, 32'h0,        1'b0);
        do_op("wr_miss",   1'b1, 8'h42, 32'hDEADBEEF, 8, 0, 3, 5, 1'b0, 32'h0,        1'b0);
        do_op("rd_wr_ln",  1'b0, 8'h42, 32'h0,        8, 1, 0, 4, 1'b1, 32'hDEADBEEF, 1'b0);
        do_op("wr_hit",    1'b1, 8'h20, 32'h0BADF00D, 8, 0, 2, 4, 1'b1, 32'h0,        1'b0);
        do_op("rd_20",     1'b0, 8'h20, 32'h0,        8, 1, 0, 4, 1'b1, 32'h0BADF00D, 1'b0);
        never_hit = 1;
        do_op("wr_tmo",    1'b1, 8'h55, 32'h55AA55AA, 24, 0, 16, 18, 1'b0, 32'h0,      1'b1);
        never_hit = 0;

        // Stall a response, then fill the FIFO behind it.
        push(1'b0, 8'h20, 32'h0);
        watch(6, rd_n, wr_n, rd_k, wr_k, resp_k, o_addr, o_val);
        chk("bp_a_resp_at", resp_k, 4);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk($sformatf("bp_ready_%0d", i), req_ready, 1);
            req_valid = 1'b1; req_write = bp_wr[i]; req_addr = bp_addr[i]; req_data = bp_data[i];
        end
        @(negedge clock);
        chk("bp_full", req_ready, 0);
        req_write = 1'b0; req_addr = 8'h77; req_data = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk($sformatf("bp_5th_blocked_%0d", i), req_ready, 0);
        end
        req_valid = 1'b0;
        accept("bp_a", 1'b1, 32'h0BADF00D, 1'b0);
        for (int i = 0; i < 4; i++) begin
            wait_resp(20);
            accept($sformatf("bp_%0d", i), bp_hit[i], bp_rdata[i], 1'b0);
        end
        watch(12, rd_n, wr_n, rd_k, wr_k, resp_k, o_addr, o_val);
        chk("bp_no_5th_rd", rd_n, 0);
        chk("bp_no_5th_wr", wr_n, 0);
        chk("bp_no_5th_resp", resp_k, 0);
        chk("bp_empty_ready", req_ready, 1);
`ifdef CACHE_SEQ_STATS_EN
        chk("stat_hits", stat_hits, 8);
        chk("stat_misses", stat_misses, 4);
`endif

        // Reset while the write is waiting, with another request queued.
        never_hit = 1;
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h66; req_data = 32'h66666666;
        @(negedge clock);
        req_write = 1'b0; req_addr = 8'h10; req_data = '0;
        @(negedge clock);
        req_valid = 1'b0;
        chk("rst_mid_issue", c_write, 1);
        @(negedge clock);
        chk("rst_mid_wait", c_write, 1);
        reset = 1'b1;
        @(negedge clock);
        chk("rst_mid_c_write", c_write, 0);
        chk("rst_mid_resp_valid", resp_valid, 0);
        chk("rst_mid_req_ready", req_ready, 1);
        reset = 1'b0;
        never_hit = 0;
        watch(10, rd_n, wr_n, rd_k, wr_k, resp_k, o_addr, o_val);
        chk("rst_mid_no_rd", rd_n, 0);
        chk("rst_mid_no_wr", wr_n, 0);
        chk("rst_mid_no_resp", resp_k, 0);
`ifdef CACHE_SEQ_STATS_EN
        chk("stat_hits_rst", stat_hits, 0);
        chk("stat_misses_rst", stat_misses, 0);
`endif
        chk("rw_exclusive", both_hi, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
